// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage and IF/ID pipeline register: owns the PC, drives the
// busywait instruction-memory handshake and absorbs stalls, waits and redirects.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC_ID,
  output logic [31:0] PC_PLUS4_ID,
  output logic        VALID_ID
);

  localparam logic [1:0] ST_START   = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc_plus4_id_q, pc_plus4_id_d;
  logic        valid_id_q, valid_id_d;

  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        complete;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Wraps modulo 2^32 by construction of the 32-bit sum.
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  assign IMEM_ADDR = pc_q;
  assign IMEM_READ = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
  assign complete  = IMEM_READ && !IMEM_BUSYWAIT;
  assign target    = word_align(BRANCH_TARGET);
  assign pc_plus4  = next_word(pc_q);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redir_d       = redir_q;
    skid_d        = skid_q;
    skid_pc_d     = skid_pc_q;
    instr_d       = instr_q;
    pc_id_d       = pc_id_q;
    pc_plus4_id_d = pc_plus4_id_q;
    valid_id_d    = valid_id_q;

    case (state_q)
      ST_START: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (BRANCH_TAKEN) begin
          instr_d    = NOP_INSTR;
          valid_id_d = 1'b0;
          if (complete) begin
            pc_d = target;
          end else begin
            // The outstanding request cannot be aborted; drain it first.
            redir_d = target;
            state_d = ST_DISCARD;
          end
        end else if (complete) begin
          pc_d = pc_plus4;
          if (!STALL) begin
            instr_d       = IMEM_READDATA;
            pc_id_d       = pc_q;
            pc_plus4_id_d = pc_plus4;
            valid_id_d    = 1'b1;
          end else begin
            skid_d    = IMEM_READDATA;
            skid_pc_d = pc_q;
            state_d   = ST_HOLD;
          end
        end else if (!STALL) begin
          instr_d    = NOP_INSTR;
          valid_id_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (BRANCH_TAKEN) begin
          instr_d    = NOP_INSTR;
          valid_id_d = 1'b0;
          pc_d       = target;
          state_d    = ST_FETCH;
        end else if (!STALL) begin
          instr_d       = skid_q;
          pc_id_d       = skid_pc_q;
          pc_plus4_id_d = next_word(skid_pc_q);
          valid_id_d    = 1'b1;
          state_d       = ST_FETCH;
        end
      end

      ST_DISCARD: begin
        instr_d    = NOP_INSTR;
        valid_id_d = 1'b0;
        if (BRANCH_TAKEN) begin
          redir_d = target;
        end
        // A redirect arriving in the draining cycle itself is the newest one.
        if (complete) begin
          pc_d    = BRANCH_TAKEN ? target : redir_q;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_START;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_START;
      pc_q          <= RESET_PC;
      redir_q       <= 32'h0;
      skid_q        <= 32'h0;
      skid_pc_q     <= 32'h0;
      instr_q       <= NOP_INSTR;
      pc_id_q       <= 32'h0;
      pc_plus4_id_q <= 32'h0;
      valid_id_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redir_q       <= redir_d;
      skid_q        <= skid_d;
      skid_pc_q     <= skid_pc_d;
      instr_q       <= instr_d;
      pc_id_q       <= pc_id_d;
      pc_plus4_id_q <= pc_plus4_id_d;
      valid_id_q    <= valid_id_d;
    end
  end

  assign INSTRUCTION = instr_q;
  assign PC_ID       = pc_id_q;
  assign PC_PLUS4_ID = pc_plus4_id_q;
  assign VALID_ID    = valid_id_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed timing checks plus a randomized run
// scored against a program-order model of which fetched words must reach decode.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] PC0_B = 32'hFFFF_FFF8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        busy = 1'b0;
  logic        stall = 1'b0;
  logic        bt = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic [31:0] garbage = 32'hDEAD_BEEF;

  logic [31:0] imem_addr, imem_rdata, instr, pc_id, pc_p4;
  logic        imem_read, valid_id;
  logic [31:0] addr_b, rdata_b, instr_b, pc_id_b, pc_p4_b;
  logic        read_b, valid_b;

  int tests = 0;
  int fails = 0;
  int delivered = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t exp_q[$];

  // Memory contents: a tag derived from the address, never equal to the NOP.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  assign imem_rdata = (imem_read && !busy) ? memword(imem_addr) : garbage;
  assign rdata_b    = memword(addr_b);

  always #5 CLK = ~CLK;

  instruction_fetch_unit u_dut (
    .CLK(CLK), .RESET(RESET),
    .IMEM_ADDR(imem_addr), .IMEM_READ(imem_read),
    .IMEM_READDATA(imem_rdata), .IMEM_BUSYWAIT(busy),
    .STALL(stall), .BRANCH_TAKEN(bt), .BRANCH_TARGET(tgt),
    .INSTRUCTION(instr), .PC_ID(pc_id), .PC_PLUS4_ID(pc_p4), .VALID_ID(valid_id)
  );

  instruction_fetch_unit #(.RESET_PC(PC0_B)) u_wrap (
    .CLK(CLK), .RESET(RESET),
    .IMEM_ADDR(addr_b), .IMEM_READ(read_b),
    .IMEM_READDATA(rdata_b), .IMEM_BUSYWAIT(1'b0),
    .STALL(1'b0), .BRANCH_TAKEN(1'b0), .BRANCH_TARGET(32'h0),
    .INSTRUCTION(instr_b), .PC_ID(pc_id_b), .PC_PLUS4_ID(pc_p4_b), .VALID_ID(valid_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: every request must issue at the architecturally next PC
  // (previous+4, or the latest redirect target); a completed word reaches
  // decode unless a redirect arrives before it is handed over.
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] req_addr = 32'h0;
  logic        req_active = 1'b0;
  logic        req_drop = 1'b0;

  always begin
    @(negedge CLK);
    #1;
    if (!RESET) begin
      exp_q.delete();
      exp_addr   = 32'h0;
      req_active = 1'b0;
      req_drop   = 1'b0;
    end else begin
      if (imem_read) begin
        if (!req_active) begin
          chk("fetch_addr", imem_addr, exp_addr);
          req_active = 1'b1;
          req_drop   = 1'b0;
          req_addr   = imem_addr;
        end else begin
          chk("addr_stable", imem_addr, req_addr);
        end
      end
      if (bt) begin
        exp_q.delete();
        if (req_active) req_drop = 1'b1;
        exp_addr = tgt & ~32'd3;
      end
      if (imem_read && !busy) begin
        req_active = 1'b0;
        if (!req_drop) begin
          exp_addr = req_addr + 32'd4;
          exp_q.push_back('{pc: req_addr, ins: memword(req_addr)});
        end
      end
    end
  end

  // Monitor: each newly loaded real IF/ID entry must be the next expected one.
  logic        prev_v = 1'b0;
  logic [31:0] prev_pc = 32'h0;
  logic [31:0] prev_ins = 32'h0;

  always @(negedge CLK) begin
    if (!RESET) begin
      prev_v = 1'b0;
    end else begin
      if (!valid_id) chk("bubble_is_nop", instr, NOP);
      if (valid_id && (!prev_v || pc_id !== prev_pc || instr !== prev_ins)) begin
        delivered++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got pc %h, expected no entry", pc_id);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_pc", pc_id, e.pc);
          chk("sb_instr", instr, e.ins);
          chk("sb_pc_plus4", pc_p4, e.pc + 32'd4);
        end
      end
      prev_v   = valid_id;
      prev_pc  = pc_id;
      prev_ins = instr;
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_read", {31'h0, imem_read}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc_id", pc_id, 32'h0);
    chk("rst_pc4", pc_p4, 32'h0);
    chk("rst_valid", {31'h0, valid_id}, 32'd0);
    chk("rst_addr_b", addr_b, PC0_B);
    RESET = 1'b1;
    chk("start_read", {31'h0, imem_read}, 32'd0);
    tick();  // E1: START -> FETCH
    chk("e1_valid", {31'h0, valid_id}, 32'd0);
    chk("e1_read", {31'h0, imem_read}, 32'd1);
    chk("e1_read_b", {31'h0, read_b}, 32'd1);
    tick();  // E2: first instruction
    chk("e2_valid", {31'h0, valid_id}, 32'd1);
    chk("e2_instr", instr, memword(32'h0));
    chk("e2_pc", pc_id, 32'h0);
    chk("e2_pc4", pc_p4, 32'h4);
    chk("e2_addr", imem_addr, 32'h4);
    chk("wrap_pc0", pc_id_b, 32'hFFFF_FFF8);
    tick();  // E3
    chk("e3_instr", instr, memword(32'h4));
    chk("e3_addr", imem_addr, 32'h8);
    chk("wrap_pc1", pc_id_b, 32'hFFFF_FFFC);
    chk("wrap_pc4_1", pc_p4_b, 32'h0);
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_valid", {31'h0, valid_id}, 32'd0);
      chk("wait_instr", instr, NOP);
      chk("wait_pc_kept", pc_id, 32'h4);
      chk("wait_addr", imem_addr, 32'h8);
      if (i == 0) begin
        chk("wrap_pc2", pc_id_b, 32'h0);
        chk("wrap_instr2", instr_b, memword(32'h0));
      end
    end
    busy = 1'b0;
    tick();  // word@8 after 3 bubbles
    chk("after_wait_pc", pc_id, 32'h8);
    chk("after_wait_instr", instr, memword(32'h8));
    chk("addr_c", imem_addr, 32'hC);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_pc", pc_id, 32'h8);
      chk("hold_valid", {31'h0, valid_id}, 32'd1);
      chk("hold_read", {31'h0, imem_read}, 32'd0);
    end
    stall = 1'b0;
    tick();  // skid enters IF/ID
    chk("skid_pc", pc_id, 32'hC);
    chk("skid_instr", instr, memword(32'hC));
    chk("skid_addr", imem_addr, 32'h10);
    chk("skid_read", {31'h0, imem_read}, 32'd1);
    tick();
    chk("after_skid_pc", pc_id, 32'h10);
    chk("addr_14", imem_addr, 32'h14);
    busy = 1'b1; bt = 1'b1; tgt = 32'h0000_0101;
    tick();
    chk("redir_flush", {31'h0, valid_id}, 32'd0);
    chk("discard_addr", imem_addr, 32'h14);
    tgt = 32'h0000_0202;
    tick();
    chk("discard_addr2", imem_addr, 32'h14);
    busy = 1'b0; bt = 1'b0;
    tick();
    chk("redir_addr", imem_addr, 32'h200);
    chk("redir_bubble", {31'h0, valid_id}, 32'd0);
    tick();
    chk("redir_pc", pc_id, 32'h200);
    chk("redir_instr", instr, memword(32'h200));
    stall = 1'b1;
    tick();
    chk("hold2_read", {31'h0, imem_read}, 32'd0);
    bt = 1'b1; tgt = 32'h0000_0043;
    tick();
    chk("hold_flush_valid", {31'h0, valid_id}, 32'd0);
    chk("hold_flush_addr", imem_addr, 32'h40);
    bt = 1'b0; stall = 1'b0;
    tick();
    chk("hold_redir_pc", pc_id, 32'h40);
    busy = 1'b1;
    tick();
    #3 RESET = 1'b0;
    #1;
    chk("mid_rst_read", {31'h0, imem_read}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_instr", instr, NOP);
    chk("mid_rst_pc", pc_id, 32'h0);
    chk("mid_rst_pc4", pc_p4, 32'h0);
    chk("mid_rst_valid", {31'h0, valid_id}, 32'd0);
    busy = 1'b0;
    tick(); tick();
    RESET = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      busy    = ($urandom_range(0, 9) < 3);
      stall   = ($urandom_range(0, 9) < 2);
      bt      = (i >= 3) && ($urandom_range(0, 19) == 0);
      tgt     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                            : $urandom_range(0, 4095);
      garbage = $urandom;
      tick();
    end
    busy = 1'b0; stall = 1'b0; bt = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("drain", (exp_q.size() <= 1) ? 32'd1 : 32'd0, 32'd1);
    chk("progress", (delivered >= 200) ? 32'd1 : 32'd0, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage and IF/ID pipeline register of the RV32IM pipeline. The block owns the PC, issues reads to the instruction memory over the busywait handshake, and presents the fetched word, with its PC, to the decode stage. Decode drives the control unit and the immediate generator. The block absorbs memory wait states, hazard-unit stalls and EX-stage branch redirects, and inserts NOP bubbles where required.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: word driven on INSTRUCTION for bubbles (addi x0,x0,0).

- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- IMEM_ADDR  out  32  fetch address; always equal to the PC register.
- IMEM_READ  out  1  read request.
- IMEM_READDATA  in  32  instruction word; valid in any cycle with IMEM_READ=1 and IMEM_BUSYWAIT=0.
- IMEM_BUSYWAIT  in  1  memory not ready.
- STALL  in  1  hazard unit: hold the IF/ID register.
- BRANCH_TAKEN  in  1  EX-stage redirect request (branch/jump resolved taken).
- BRANCH_TARGET  in  32  redirect address; bits [1:0] ignored and treated as 0.
- INSTRUCTION  out  32  IF/ID instruction to decode and immediate generator.
- PC_ID  out  32  IF/ID PC of INSTRUCTION.
- PC_PLUS4_ID  out  32  IF/ID PC_ID+4.
- VALID_ID  out  1  IF/ID entry is a real instruction (0 = bubble).

## Operation
- Request completes ("complete") on the edge ending a cycle with IMEM_READ=1 and IMEM_BUSYWAIT=0. IMEM_ADDR is stable while IMEM_READ is held.
- A "bubble" load sets INSTRUCTION=NOP_INSTR and VALID_ID=0. PC_ID and PC_PLUS4_ID keep their values.
- A "flush" is a bubble load that ignores STALL.
- Internal registers: PC, REDIR (32), SKID and SKID_PC (32 each), state.
- States:
  - START: IMEM_READ=0. Always goes to FETCH next cycle.
  - FETCH: IMEM_READ=1.
    - BRANCH_TAKEN has priority. Flush IF/ID. If complete: PC←BRANCH_TARGET and stay in FETCH; the returned word is dropped. If not complete: REDIR←BRANCH_TARGET, go to DISCARD.
    - Complete, STALL=0: IF/ID←{READDATA, PC, PC+4, VALID=1}; PC←PC+4.
    - Complete, STALL=1: SKID←READDATA, SKID_PC←PC; PC←PC+4; go to HOLD. IF/ID unchanged.
    - Not complete: STALL=0 gives a bubble load. STALL=1 leaves IF/ID unchanged.
  - HOLD: IMEM_READ=0.
    - BRANCH_TAKEN: flush, discard SKID, PC←BRANCH_TARGET, go to FETCH.
    - Else STALL=0: IF/ID←{SKID, SKID_PC, SKID_PC+4, 1}, go to FETCH.
    - Else stay in HOLD.
  - DISCARD: IMEM_READ=1 at the old PC. An issued request is never aborted. IF/ID stays a bubble.
    - BRANCH_TAKEN updates REDIR; the latest target wins.
    - On complete: data dropped; PC←BRANCH_TARGET if BRANCH_TAKEN is high that cycle, else REDIR; go to FETCH.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.

## Timing
- Reset (RESET=0, asynchronous): state=START, PC=RESET_PC, IMEM_ADDR=RESET_PC, IMEM_READ=0, INSTRUCTION=NOP_INSTR, PC_ID=0, PC_PLUS4_ID=0, VALID_ID=0, REDIR=0, SKID=0, SKID_PC=0.
- Reset asserted mid-request or mid-DISCARD abandons everything immediately. The memory must tolerate IMEM_READ dropping.
- Zero-wait memory: first VALID_ID=1 on the 2nd rising edge after RESET release (START, then FETCH). Throughput is 1 instruction/cycle after that.
- N wait cycles: N bubbles, then the instruction.
- Redirect penalty:
  - Redirect in a completing FETCH cycle: target issued the next cycle.
  - Redirect in a waiting FETCH cycle: the old request drains in DISCARD, then the target is issued.
- STALL released in HOLD: SKID enters IF/ID on that edge and the next fetch issues the following cycle. No instruction is lost or duplicated.
- All outputs are registered except IMEM_ADDR (=PC) and IMEM_READ (decoded from state).

## Test plan
- Reset, zero-wait memory returning addr-tagged words, STALL=0 -> IMEM_ADDR 0,4,8,… each cycle; VALID_ID=1 from 2nd edge with INSTRUCTION=word@0, PC_ID=0, PC_PLUS4_ID=4, then consecutive words.
- BUSYWAIT high 3 cycles on addr 8 -> 3 bubbles (VALID_ID=0, INSTRUCTION=32'h13), then word@8 with PC_ID=8; IMEM_ADDR held at 8 throughout.
- STALL high 4 cycles while word@C completes -> IF/ID holds word@8, IMEM_READ=0 in HOLD; after release PC_ID=C, then fetch at 0x10; no loss or duplicate.
- BRANCH_TAKEN, target 0x100, during a BUSYWAIT cycle at 0x14, with a second BRANCH_TAKEN, target 0x200, before completion -> word@14 dropped, VALID_ID=0, next IMEM_ADDR=0x200, then PC_ID=0x200.
- BRANCH_TAKEN with STALL=1 in HOLD, target 0x40 -> flush overrides stall (VALID_ID=0 next edge), SKID discarded, IMEM_ADDR=0x40.
- RESET_PC=32'hFFFF_FFF8, zero-wait -> PC_ID sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; PC_PLUS4_ID at FFFF_FFFC = 0. Also assert RESET mid-wait -> all outputs at their reset values immediately.
